// File: rtl/inbuf_sched.sv
// Row-buffer sequencer: loads a host stream row-major into ROWS buffers, then
// issues diagonally skewed read strobes and tracks per-row occupancy.
module inbuf_sched #(
    parameter int WORDLEN = 8,
    parameter int ROWS    = 4,
    parameter int DEPTH   = 16,
    parameter int KW      = 5
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic [KW-1:0]      k_len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORDLEN-1:0] in_data,
    output logic [WORDLEN-1:0] buf_din,
    output logic [ROWS-1:0]    buf_write,
    output logic [ROWS-1:0]    buf_read,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
    output logic               occ_err,
    output logic [1:0]         dbg_state
);

    // Handshake: a host word moves on any rising clk edge where in_valid and
    // in_ready are both high; in_valid may change freely while in_ready is low.

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int TW = $clog2(DEPTH + ROWS) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state, state_nx;
    logic [KW-1:0]   k_q;
    logic [KW-1:0]   wcnt;
    logic [RW-1:0]   row;
    logic            drain;
    logic [TW-1:0]   t_q;
    logic [TW-1:0]   k_ext;
    logic [TW-1:0]   t_last;
    logic            k_ok;
    logic            xfer;
    logic [ROWS-1:0] row_hot;
    logic [KW-1:0]   occ [ROWS];
    logic [ROWS-1:0] wr_full;
    logic [ROWS-1:0] rd_empty;

    assign k_ok      = (k_len != '0) && (k_len <= KW'(DEPTH));
    assign in_ready  = (state == LOAD) && !drain;
    assign xfer      = in_valid && in_ready;
    assign busy      = (state == LOAD) || (state == STREAM);
    assign done      = (state == DONE);
    assign dbg_state = state;
    assign k_ext     = TW'(k_q);
    assign t_last    = k_ext + TW'(ROWS - 2);

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (start && k_ok) state_nx = LOAD;
            LOAD:   if (drain) state_nx = STREAM;
            STREAM: if (t_q == t_last) state_nx = DONE;
            DONE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        row_hot = '0;
        row_hot[row] = 1'b1;
    end

    // drain holds LOAD for the cycle of the final write, so streaming starts
    // only after the last row buffer is complete.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            k_q       <= '0;
            wcnt      <= '0;
            row       <= '0;
            drain     <= 1'b0;
            t_q       <= '0;
            buf_din   <= '0;
            buf_write <= '0;
            cfg_err   <= 1'b0;
        end else begin
            buf_write <= '0;
            cfg_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (k_ok) begin
                            k_q   <= k_len;
                            wcnt  <= '0;
                            row   <= '0;
                            drain <= 1'b0;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    t_q <= '0;
                    if (xfer) begin
                        buf_din   <= in_data;
                        buf_write <= row_hot;
                        if (wcnt == k_q - 1'b1) begin
                            wcnt <= '0;
                            if (row == RW'(ROWS - 1)) drain <= 1'b1;
                            else                      row   <= row + 1'b1;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end
                STREAM: t_q <= t_q + 1'b1;
                default: ;
            endcase
        end
    end

    // Row r is read during the K cycles starting r cycles after row 0.
    always_comb begin
        buf_read = '0;
        if (state == STREAM) begin
            for (int r = 0; r < ROWS; r++) begin
                buf_read[r] = (t_q >= TW'(r)) && (t_q < TW'(r) + k_ext);
            end
        end
    end

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            wr_full[r]  = buf_write[r] && (occ[r] == KW'(DEPTH));
            rd_empty[r] = buf_read[r] && (occ[r] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int r = 0; r < ROWS; r++) occ[r] <= '0;
            occ_err <= 1'b0;
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                if (buf_write[r] && !buf_read[r] && !wr_full[r])
                    occ[r] <= occ[r] + 1'b1;
                else if (buf_read[r] && !buf_write[r] && !rd_empty[r])
                    occ[r] <= occ[r] - 1'b1;
            end
            occ_err <= occ_err | (|wr_full) | (|rd_empty);
        end
    end

endmodule

// File: tb/tb_inbuf_sched.sv
// Bench for inbuf_sched: vector table for reset/tile/config cases, plus
// hand sequences for backpressure, interference, mid-stream reset, full depth.
module tb_inbuf_sched;

    localparam int WORDLEN = 8;
    localparam int ROWS    = 4;
    localparam int DEPTH   = 16;
    localparam int KW      = 5;

    logic               clk = 1'b0;
    logic               rstn;
    logic               start;
    logic [KW-1:0]      k_len;
    logic               in_valid;
    logic               in_ready;
    logic [WORDLEN-1:0] in_data;
    logic [WORDLEN-1:0] buf_din;
    logic [ROWS-1:0]    buf_write;
    logic [ROWS-1:0]    buf_read;
    logic               busy;
    logic               done;
    logic               cfg_err;
    logic               occ_err;
    logic [1:0]         dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [WORDLEN-1:0] exp_q[$];

    typedef struct {
        logic         rstn;
        logic         start;
        logic [KW-1:0] k;
        logic         v;
        logic [7:0]   d;
        logic         rdy;
        logic [3:0]   wr;
        logic [7:0]   din;
        logic [3:0]   rd;
        logic         busy;
        logic         done;
        logic         cfg;
    } vec_t;

    vec_t tbl[$];

    inbuf_sched #(.WORDLEN(WORDLEN), .ROWS(ROWS), .DEPTH(DEPTH), .KW(KW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .buf_din(buf_din), .buf_write(buf_write), .buf_read(buf_read),
        .busy(busy), .done(done), .cfg_err(cfg_err), .occ_err(occ_err),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic s, input int k, input logic v, input int d,
                       input logic rdy, input logic [3:0] wr, input logic [3:0] rd,
                       input logic b, input logic dn, input logic cfg);
        vec_t e;
        e.rstn = r; e.start = s; e.k = KW'(k); e.v = v; e.d = 8'(d);
        e.rdy = rdy; e.wr = wr; e.din = 8'(d); e.rd = rd;
        e.busy = b; e.done = dn; e.cfg = cfg;
        tbl.push_back(e);
    endtask

    // mode 0: in_valid always high, 1: alternating, 2: random
    task automatic run_tile(input int k, input int mode, input bit glitch);
        int c, writes, last_w, s, done_c, n_sent, rrow;
        int occ[ROWS];
        int peak[ROWS];
        logic pre_ready;
        logic [ROWS-1:0] exp_wr, exp_rd;
        for (int r = 0; r < ROWS; r++) begin occ[r] = 0; peak[r] = 0; end
        c = 0; writes = 0; last_w = -1; s = -1; done_c = -1; n_sent = 0;
        start = 1'b1; k_len = KW'(k); in_valid = 1'b0;
        tick();
        start = 1'b0;
        check($sformatf("k%0d busy_after_start", k), busy, 1);
        for (int cyc = 0; cyc < 2000 && done_c < 0; cyc++) begin
            case (mode)
                0:       in_valid = (n_sent < ROWS * k);
                1:       in_valid = (n_sent < ROWS * k) && (cyc % 2 == 0);
                default: in_valid = (n_sent < ROWS * k) && ($urandom_range(0, 1) == 1);
            endcase
            in_data = 8'($urandom_range(0, 255));
            start   = glitch && (cyc == 3);
            k_len   = (glitch && cyc == 3) ? '0 : KW'(k);
            pre_ready = in_ready;
            if (in_valid && pre_ready) begin
                exp_q.push_back(in_data);
                n_sent++;
            end
            tick();
            c++;
            start = 1'b0;
            if (buf_write != '0) begin
                writes++;
                last_w = c;
                rrow = (writes - 1) / k;
                exp_wr = '0;
                if (rrow < ROWS) exp_wr[rrow] = 1'b1;
                check($sformatf("k%0d write%0d row", k, writes), buf_write, exp_wr);
                if (exp_q.size() > 0)
                    check($sformatf("k%0d write%0d data", k, writes), buf_din, exp_q.pop_front());
                else
                    check($sformatf("k%0d write%0d unexpected", k, writes), 1, 0);
            end
            if (s < 0 && dbg_state == 2'd2) s = c;
            exp_rd = '0;
            if (s >= 0)
                for (int r = 0; r < ROWS; r++)
                    if (c >= s + r && c < s + r + k) exp_rd[r] = 1'b1;
            check($sformatf("k%0d c%0d buf_read", k, c), buf_read, exp_rd);
            for (int r = 0; r < ROWS; r++) begin
                if (buf_write[r]) occ[r]++;
                if (peak[r] < occ[r]) peak[r] = occ[r];
                if (buf_read[r]) occ[r]--;
            end
            check($sformatf("k%0d c%0d cfg_err", k, c), cfg_err, 0);
            check($sformatf("k%0d c%0d occ_err", k, c), occ_err, 0);
            if (done) begin
                done_c = c;
                check($sformatf("k%0d busy_at_done", k), busy, 0);
            end
        end
        in_valid = 1'b0;
        check($sformatf("k%0d done_seen", k), (done_c >= 0), 1);
        check($sformatf("k%0d write_count", k), writes, ROWS * k);
        check($sformatf("k%0d stream_after_last_write", k), s, last_w + 1);
        check($sformatf("k%0d done_cycle", k), done_c, s + k + ROWS - 1);
        for (int r = 0; r < ROWS; r++) begin
            check($sformatf("k%0d occ_peak_row%0d", k, r), peak[r], k);
            check($sformatf("k%0d occ_end_row%0d", k, r), occ[r], 0);
        end
        check($sformatf("k%0d exp_q_empty", k), exp_q.size(), 0);
        tick();
        check($sformatf("k%0d idle_after_done", k), dbg_state, 0);
        exp_q.delete();
    endtask

    initial begin
        rstn = 1'b0; start = 1'b1; k_len = 5'd3; in_valid = 1'b0; in_data = '0;

        // reset held with start high, then a k=3 tile, then config errors
        for (int i = 0; i < 3; i++) add(0, 1, 3, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
        add(1, 1, 3, 0, 0, 1, 4'b0000, 4'b0000, 1, 0, 0);
        for (int j = 1; j <= 12; j++)
            add(1, 0, 3, 1, j, (j < 12), 4'(1 << ((j - 1) / 3)), 4'b0000, 1, 0, 0);
        add(1, 0, 3, 0, 0, 0, 4'b0000, 4'b0001, 1, 0, 0);
        add(1, 0, 3, 0, 0, 0, 4'b0000, 4'b0011, 1, 0, 0);
        add(1, 0, 3, 0, 0, 0, 4'b0000, 4'b0111, 1, 0, 0);
        add(1, 0, 3, 0, 0, 0, 4'b0000, 4'b1110, 1, 0, 0);
        add(1, 0, 3, 0, 0, 0, 4'b0000, 4'b1100, 1, 0, 0);
        add(1, 0, 3, 0, 0, 0, 4'b0000, 4'b1000, 1, 0, 0);
        add(1, 0, 3, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 0);
        add(1, 0, 3, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
        add(1, 1, 17, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1);
        add(1, 0, 17, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
        add(1, 1, 31, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1);
        add(1, 0, 3, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            rstn = tbl[i].rstn; start = tbl[i].start; k_len = tbl[i].k;
            in_valid = tbl[i].v; in_data = tbl[i].d;
            tick();
            check($sformatf("v%0d in_ready", i), in_ready, tbl[i].rdy);
            check($sformatf("v%0d buf_write", i), buf_write, tbl[i].wr);
            if (tbl[i].wr != '0) check($sformatf("v%0d buf_din", i), buf_din, tbl[i].din);
            check($sformatf("v%0d buf_read", i), buf_read, tbl[i].rd);
            check($sformatf("v%0d busy", i), busy, tbl[i].busy);
            check($sformatf("v%0d done", i), done, tbl[i].done);
            check($sformatf("v%0d cfg_err", i), cfg_err, tbl[i].cfg);
            check($sformatf("v%0d occ_err", i), occ_err, 0);
            if (tbl[i].rstn == 1'b0) begin
                check($sformatf("v%0d reset_state", i), dbg_state, 0);
                check($sformatf("v%0d reset_din", i), buf_din, 0);
            end
        end
        start = 1'b0; in_valid = 1'b0;

        run_tile(2, 1, 1'b0);
        run_tile(3, 2, 1'b1);

        // reset at STREAM t=2
        start = 1'b1; k_len = 5'd3;
        tick();
        start = 1'b0; in_valid = 1'b1;
        for (int j = 0; j < 12; j++) begin
            in_data = 8'(j + 40);
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 10 && dbg_state != 2'd2; i++) tick();
        check("rst_stream_entry", dbg_state, 2);
        tick();
        tick();
        check("rst_t2_read", buf_read, 4'b0111);
        rstn = 1'b0;
        tick();
        check("rst_state", dbg_state, 0);
        check("rst_buf_read", buf_read, 0);
        check("rst_buf_write", buf_write, 0);
        check("rst_busy", busy, 0);
        check("rst_occ_err", occ_err, 0);
        rstn = 1'b1;
        tick();
        check("rst_release_state", dbg_state, 0);
        check("rst_release_done", done, 0);

        // leftover occupancy would overflow a full-depth tile
        run_tile(DEPTH, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
